// File: rtl/adder_2bit_seq_ctrl.sv
// ============================================================================
// Module   : adder_2bit_seq_ctrl
// Brief    : Serial WIDTH-bit adder. It adds two bits per clock through one
//            shared 2-bit full-adder slice and has a start/busy/done handshake.
//            Optional subtract mode is enabled by defining ADDER_SEQ_SUB_EN.
//            WIDTH must be even and at least 2.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_2bit_slice (
    input  logic [1:0] a_i,
    input  logic [1:0] b_i,
    input  logic       cin_i,
    output logic [1:0] s_o,
    output logic       cout_o
);
    assign {cout_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {2'b00, cin_i};
endmodule

module adder_2bit_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
`ifdef ADDER_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co
);
    localparam int C_STEPS = WIDTH / 2;
    localparam int CNT_W   = (C_STEPS > 1) ? $clog2(C_STEPS) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(C_STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             co_q, co_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0]       w_slice_s;
    logic             w_slice_co;
    logic [WIDTH-1:0] w_acc_shift;
    logic [WIDTH-1:0] w_b_load;
    logic             w_c_load;

    adder_2bit_slice u_slice (
        .a_i    (a_sh_q[1:0]),
        .b_i    (b_sh_q[1:0]),
        .cin_i  (carry_q),
        .s_o    (w_slice_s),
        .cout_o (w_slice_co)
    );

    // Each new digit pair enters at the MSB end, so after N steps the
    // accumulator holds the full result in natural bit order.
    generate
        if (WIDTH > 2) begin : g_acc_wide
            assign w_acc_shift = {w_slice_s, acc_q[WIDTH-1:2]};
        end else begin : g_acc_narrow
            assign w_acc_shift = w_slice_s;
        end
    endgenerate

`ifdef ADDER_SEQ_SUB_EN
    // Subtract: a - b is computed as a + ~b + 1. co=1 means no borrow.
    assign w_b_load = sub ? ~b : b;
    assign w_c_load = sub ? 1'b1 : ci;
`else
    assign w_b_load = b;
    assign w_c_load = ci;
`endif

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        co_d    = co_q;
        cnt_d   = cnt_q;
        busy    = 1'b0;
        done    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = w_b_load;
                    carry_d = w_c_load;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                busy    = 1'b1;
                acc_d   = w_acc_shift;
                carry_d = w_slice_co;
                a_sh_d  = a_sh_q >> 2;
                b_sh_d  = b_sh_q >> 2;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == C_LAST) begin
                    sum_d   = w_acc_shift;
                    co_d    = w_slice_co;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sum = sum_q;
    assign co  = co_q;

endmodule

`default_nettype wire

// File: tb/tb_adder_2bit_seq_ctrl.sv
// ============================================================================
// Module   : tb_adder_2bit_seq_ctrl
// Brief    : Self-checking bench for adder_2bit_seq_ctrl (WIDTH=8). It uses
//            vector tables, a result scoreboard, and hand-written corner cases.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder_2bit_seq_ctrl;
    localparam int WIDTH = 8;
    localparam int N     = WIDTH / 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
`ifdef ADDER_SEQ_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             co;

    adder_2bit_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .ci    (ci),
`ifdef ADDER_SEQ_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .co    (co)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             ci;
        logic [WIDTH-1:0] exp_sum;
        logic             exp_co;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [WIDTH:0] sb_q[$];
    vec_t        vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives one operation from an IDLE cycle and follows it for N+2 edges.
    // It returns one edge after done, so the next call is a back-to-back start.
    // mode 1 re-asserts start with new operands while busy.
    task automatic run_op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                          input logic ici, input logic isub, input int mode,
                          input logic [WIDTH:0] exp);
        int done_cyc  = -1;
        int done_cnt  = 0;
        int busy_bad  = 0;
        logic [WIDTH:0] got;
        a = ia; b = ib; ci = ici; start = 1'b1;
`ifdef ADDER_SEQ_SUB_EN
        sub = isub;
`else
        if (isub) $display("note: sub request ignored in add-only build");
`endif
        sb_q.push_back(exp);
        for (int c = 1; c <= N + 2; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                if (mode == 1) begin
                    start = 1'b1; a = 8'hFF; b = 8'h00; ci = 1'b1;
                end else begin
                    start = 1'b0;
                end
            end else begin
                start = 1'b0;
                a = ~a;
                b = b + 8'd3;
            end
            if (busy !== (c <= N + 1)) busy_bad++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
                if (sb_q.size() == 0) begin
                    chk("scoreboard_empty", 32'd0, 32'd1);
                end else begin
                    got = sb_q.pop_front();
                    chk("result", {23'd0, co, sum}, {23'd0, got});
                end
            end
            if (c == N + 2) chk("result_hold", {23'd0, co, sum}, {23'd0, exp});
        end
        chk("done_edge", done_cyc, N + 1);
        chk("done_pulses", done_cnt, 1);
        chk("busy_pattern", busy_bad, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int stray_done;
        vecs[0] = '{8'hA5, 8'h3C, 1'b0, 8'hE1, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1};
        vecs[6] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
        vecs[7] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};

        rst = 1'b1; start = 1'b1; a = 8'hFF; b = 8'hFF; ci = 1'b1;
`ifdef ADDER_SEQ_SUB_EN
        sub = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {28'd0, busy, done, co, |sum}, 32'd0);
        start = 1'b0;
        rst   = 1'b0;
        @(posedge clk); #1;
        chk("idle_after_reset", {30'd0, busy, done}, 32'd0);

        for (int i = 0; i < 8; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].ci, 1'b0, 0,
                   {vecs[i].exp_co, vecs[i].exp_sum});

        // This start arrives while busy and must be ignored. The next call
        // is a back-to-back start that must be accepted.
        run_op(8'h12, 8'h34, 1'b0, 1'b0, 1, {1'b0, 8'h46});
        run_op(8'h01, 8'h02, 1'b0, 1'b0, 0, {1'b0, 8'h03});

        // rst is sampled at edge 3 during RUN. The operation is abandoned
        // with no done pulse.
        stray_done = 0;
        a = 8'h77; b = 8'h11; ci = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0; stray_done += int'(done);
        @(posedge clk); #1; rst = 1'b1;   stray_done += int'(done);
        @(posedge clk); #1; rst = 1'b0;   stray_done += int'(done);
        chk("midrun_reset_clear", {28'd0, busy, done, co, |sum}, 32'd0);
        for (int c = 0; c < N + 2; c++) begin
            @(posedge clk); #1;
            stray_done += int'(done);
        end
        chk("midrun_reset_no_done", stray_done, 0);
        chk("midrun_reset_hold", {23'd0, co, sum}, 32'd0);
        run_op(8'hC3, 8'h5A, 1'b1, 1'b0, 0, {1'b1, 8'h1E});

`ifdef ADDER_SEQ_SUB_EN
        run_op(8'h10, 8'h01, 1'b0, 1'b1, 0, {1'b1, 8'h0F});
        run_op(8'h01, 8'h02, 1'b0, 1'b1, 0, {1'b0, 8'hFF});
        run_op(8'h40, 8'h40, 1'b0, 1'b1, 0, {1'b1, 8'h00});
        run_op(8'h01, 8'h02, 1'b1, 1'b1, 0, {1'b0, 8'hFF});
`endif

        chk("scoreboard_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
